// File: rtl/router_pkt_tx.sv
// router_pkt_tx: buffers one payload from a byte producer, then drives the router
// with a header byte, the payload bytes and an XOR parity byte, holding each byte while busy.
module router_pkt_tx #(
    parameter int MAX_LEN = 63
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [1:0] dest_addr,
    input  logic [5:0] payload_len,
    input  logic       corrupt_parity,
    input  logic       pl_valid,
    input  logic [7:0] pl_data,
    output logic       pl_ready,
    input  logic       busy,
    output logic       pkt_valid,
    output logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       done,
    output logic       err
);
    typedef enum logic [2:0] {IDLE, LOAD, HEADER, PAYLOAD, PARITY} state_t;
    localparam logic [5:0] MAX6 = 6'(MAX_LEN);
    state_t state, state_n;
    logic [5:0] len, wr_cnt, rd_cnt, rd_cnt_n;
    logic [7:0] hdr, par, par_tx;
    logic [7:0] mem [MAX_LEN];
    logic corrupt, req_ok, accept, xfer;
    always_comb begin
        req_ok = dest_addr != 2'd3 && payload_len != 6'd0 && payload_len <= MAX6;
        accept = state == IDLE && start && req_ok;
        xfer = state == LOAD && pl_valid;
        par_tx = corrupt ? ~par : par;
        state_n = state;
        rd_cnt_n = rd_cnt;
        case (state)
            IDLE:    state_n = accept ? LOAD : IDLE;
            LOAD:    state_n = xfer && wr_cnt + 6'd1 == len ? HEADER : LOAD;
            HEADER: begin
                state_n = busy ? HEADER : PAYLOAD;
                rd_cnt_n = busy ? rd_cnt : 6'd0;
            end
            PAYLOAD: begin
                state_n = !busy && rd_cnt + 6'd1 == len ? PARITY : PAYLOAD;
                rd_cnt_n = !busy && rd_cnt + 6'd1 != len ? rd_cnt + 6'd1 : rd_cnt;
            end
            PARITY:  state_n = busy ? PARITY : IDLE;
            default: state_n = IDLE;
        endcase
    end
    // Outputs are registered from the next state so each byte appears the cycle its state begins.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            len <= 6'd0;
            wr_cnt <= 6'd0;
            rd_cnt <= 6'd0;
            hdr <= 8'd0;
            par <= 8'd0;
            corrupt <= 1'b0;
            pl_ready <= 1'b0;
            pkt_valid <= 1'b0;
            tx_data <= 8'd0;
            tx_busy <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
        end else begin
            state <= state_n;
            rd_cnt <= rd_cnt_n;
            if (accept) begin
                len <= payload_len;
                hdr <= {payload_len, dest_addr};
                par <= {payload_len, dest_addr};
                corrupt <= corrupt_parity;
                wr_cnt <= 6'd0;
            end
            if (xfer) begin
                par <= par ^ pl_data;
                wr_cnt <= wr_cnt + 6'd1;
            end
            pl_ready <= state_n == LOAD;
            pkt_valid <= state_n == HEADER || state_n == PAYLOAD;
            tx_busy <= state_n != IDLE;
            tx_data <= state_n == HEADER ? hdr : state_n == PAYLOAD ? mem[rd_cnt_n] :
                       state_n == PARITY ? par_tx : 8'd0;
            done <= state == PARITY && !busy;
            err <= state == IDLE && start && !req_ok;
        end
    end
    always_ff @(posedge clk) begin
        if (xfer) mem[wr_cnt] <= pl_data;
    end
endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: randomized and directed checks of router_pkt_tx against a packet-level model.
module tb_router_pkt_tx;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic start = 1'b0;
    logic [1:0] dest_addr = 2'd0;
    logic [5:0] payload_len = 6'd0;
    logic corrupt_parity = 1'b0;
    logic pl_valid = 1'b0;
    logic [7:0] pl_data = 8'd0;
    logic busy = 1'b0;
    logic pl_ready, pkt_valid, tx_busy, done, err;
    logic [7:0] tx_data;
    int checks = 0;
    int errors = 0;
    logic [7:0] pl [64];
    logic [7:0] gotq [$];
    int last_done;

    router_pkt_tx dut (
        .clk(clk), .resetn(resetn), .start(start), .dest_addr(dest_addr),
        .payload_len(payload_len), .corrupt_parity(corrupt_parity),
        .pl_valid(pl_valid), .pl_data(pl_data), .pl_ready(pl_ready), .busy(busy),
        .pkt_valid(pkt_valid), .tx_data(tx_data), .tx_busy(tx_busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_pkt_valid"}, pkt_valid, 0);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_pl_ready"}, pl_ready, 0);
        check({tag, "_tx_busy"}, tx_busy, 0);
    endtask

    // bpct<0: fixed stall plan (3 on header, 2 on payload byte 4); gpct<0: pl_valid toggles.
    task automatic run_pkt(input logic [1:0] a, input logic [5:0] n, input logic c,
                           input int bpct, input int gpct);
        logic [7:0] expq [$];
        logic [7:0] p, hold_d;
        logic hold_v, held, in_tx;
        int idx, extra, acc, st, want;
        bit fin;
        idx = 0; extra = 0; acc = 0; st = 0; fin = 0; held = 0;
        hold_d = 0; hold_v = 0;
        gotq.delete();
        last_done = -1;
        p = {n, a};
        expq.push_back(p);
        for (int k = 0; k < int'(n); k++) begin
            expq.push_back(pl[k]);
            p ^= pl[k];
        end
        expq.push_back(c ? ~p : p);
        dest_addr = a; payload_len = n; corrupt_parity = c; start = 1'b1;
        for (int i = 1; i <= 600 && !fin; i++) begin
            @(negedge clk);
            if (i == 1) begin
                check("ready_t1", pl_ready, 1);
                check("txbusy_t1", tx_busy, 1);
            end
            check("no_err", err, 0);
            if (held) begin
                check("stall_data", tx_data, hold_d);
                check("stall_valid", pkt_valid, hold_v);
            end
            if (done) begin
                fin = 1;
                last_done = i;
                check("done_cycle", i, 2 * int'(n) + 3 + extra);
                check("done_txbusy", tx_busy, 0);
            end
            start = fin ? 1'b0 : ($urandom_range(3) == 0);
            dest_addr = 2'd3; payload_len = 6'd0;
            in_tx = tx_busy && !pl_ready;
            want = acc == 0 ? 3 : acc == 4 ? 2 : 0;
            busy = bpct < 0 ? (in_tx && st < want) : ($urandom_range(99) < bpct);
            pl_valid = gpct < 0 ? i[0] : ($urandom_range(99) >= gpct);
            pl_data = (pl_valid && pl_ready && idx < 64) ? pl[idx] : 8'($urandom);
            if (pl_ready) begin
                if (pl_valid) idx++;
                else extra++;
            end
            held = in_tx && busy;
            if (held) begin
                hold_d = tx_data; hold_v = pkt_valid; extra++; st++;
            end else if (in_tx) begin
                check("byte_valid", pkt_valid, acc <= int'(n));
                gotq.push_back(tx_data);
                acc++; st = 0;
            end
        end
        start = 1'b0; busy = 1'b0; pl_valid = 1'b0;
        if (!fin) check("timeout_done", 0, 1);
        check("byte_count", gotq.size(), expq.size());
        for (int k = 0; k < gotq.size() && k < expq.size(); k++)
            check("byte_val", gotq[k], expq[k]);
    endtask

    task automatic reject(input logic [1:0] a, input logic [5:0] n);
        dest_addr = a; payload_len = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rej_err", err, 1);
        check_quiet("rej");
        @(negedge clk);
        check("rej_err_drop", err, 0);
        check_quiet("rej_after");
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_quiet("reset");
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        resetn = 1'b1;
        @(negedge clk);
        // nominal packet
        for (int k = 0; k < 8; k++) pl[k] = 8'(k + 1);
        run_pkt(2'd2, 6'd8, 1'b0, 0, 0);
        check("nom_done_t19", last_done, 19);
        if (gotq.size() == 10) begin
            check("nom_header", gotq[0], 8'h22);
            check("nom_parity", gotq[9], 8'h2A);
        end else check("nom_size", gotq.size(), 10);
        // corrupt parity
        run_pkt(2'd2, 6'd8, 1'b1, 0, 0);
        if (gotq.size() == 10) check("bad_parity", gotq[9], 8'hD5);
        else check("bad_size", gotq.size(), 10);
        // stall plan: done delayed by exactly 5
        run_pkt(2'd2, 6'd8, 1'b0, -1, 0);
        check("stall_done_t24", last_done, 24);
        // rejected requests
        reject(2'd3, 6'd5);
        reject(2'd0, 6'd0);
        // producer gaps
        for (int k = 0; k < 4; k++) pl[k] = 8'($urandom);
        run_pkt(2'd1, 6'd4, 1'b0, 0, -1);
        // length boundaries
        pl[0] = 8'($urandom);
        run_pkt(2'd0, 6'd1, 1'b0, 0, 0);
        for (int k = 0; k < 63; k++) pl[k] = 8'($urandom);
        run_pkt(2'd2, 6'd63, 1'b1, 20, 20);
        // randomized packets, back to back
        for (int t = 0; t < 25; t++) begin
            for (int k = 0; k < 64; k++) pl[k] = 8'($urandom);
            run_pkt(2'($urandom_range(2)), 6'($urandom_range(63, 1)), 1'($urandom),
                    30, 30);
        end
        // reset during payload byte 3
        for (int k = 0; k < 8; k++) pl[k] = 8'($urandom);
        dest_addr = 2'd0; payload_len = 6'd8; corrupt_parity = 1'b0;
        start = 1'b1; pl_valid = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            start = 1'b0;
            pl_data = pl[j-1];
        end
        repeat (4) @(negedge clk);
        pl_valid = 1'b0;
        check("rst_pre_byte3", tx_data, pl[2]);
        check("rst_pre_valid", pkt_valid, 1);
        #2 resetn = 1'b0;
        #1 check_quiet("async_rst");
        @(negedge clk);
        resetn = 1'b1;
        pl[0] = 8'hFF;
        run_pkt(2'd1, 6'd1, 1'b0, 0, 0);
        if (gotq.size() == 3) begin
            check("post_rst_hdr", gotq[0], 8'h05);
            check("post_rst_pl", gotq[1], 8'hFF);
            check("post_rst_par", gotq[2], 8'hFA);
        end else check("post_rst_size", gotq.size(), 3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
